// File: rtl/if_stage_if.sv
// Instruction-memory request port of the fetch stage.
// One valid/ack transaction at a time: req and addr are held until ack,
// and ack may arrive in the same cycle as req.
interface if_stage_if;
   logic        req;    // fetch request valid
   logic [31:0] addr;   // word-aligned fetch address
   logic        ack;    // response valid
   logic [31:0] rdata;  // instruction word, valid with ack

   // Fetch stage side
   modport master (output req, addr, input ack, rdata);
   // Instruction memory side
   modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the fetch PC, issues one outstanding imem request at a time, buffers
// returned words in a small circular queue and presents them to decode.
// Redirects from ID flush the queue; a redirect that races an unacked request
// parks in DROP until that response arrives, so the stale word is never used.
module if_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned QUEUE_DEPTH = 2,
   parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,            // asynchronous, active-low
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   if_stage_if.master  imem,
   output logic [31:0] pc,
   output logic [31:0] inst,
   output logic        inst_valid
);

   localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

   typedef enum logic {
      S_FETCH,   // normal fetching
      S_DROP     // waiting to discard the response of a redirected request
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      fetch_pc_q;
   logic [31:0]      drop_target_q;
   logic             outstanding_q;

   logic [31:0]      q_pc   [QUEUE_DEPTH];
   logic [31:0]      q_inst [QUEUE_DEPTH];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q;

   logic             redirect;       // branch accepted this cycle
   logic             pending;        // a request is in flight (issued earlier or now)
   logic             ack_valid;      // ack that belongs to our request
   logic             redirect_drop;  // redirect while the in-flight request is unacked
   logic             push;
   logic             pop;
   logic [31:0]      target;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign redirect      = branch_taken & ~stall;
   assign target        = branch_addr & ~32'h0000_0003;
   assign pending       = outstanding_q | imem.req;
   assign ack_valid     = imem.ack & pending;
   assign redirect_drop = redirect & pending & ~imem.ack;
   // A redirect flushes the queue, so a same-cycle response is never written.
   assign push          = ack_valid & (state_q == S_FETCH) & ~redirect;
   assign pop           = ~stall & ~redirect & (count_q != '0);
   assign imem.addr     = fetch_pc_q;

   // FSM state register
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_FETCH;
      else      state_q <= state_d;
   end

   // FSM next state: enter DROP on a redirect that races an unacked request
   // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
   always_comb begin
      state_d = state_q;
      if (redirect)
         state_d = redirect_drop ? S_DROP : S_FETCH;
      else if ((state_q == S_DROP) && ack_valid)
         state_d = S_FETCH;
   end

   // FSM output: request while fetching and the queue has room for the reply;
   // an already-issued request stays asserted until acked
   always_comb begin
      imem.req = 1'b0;
      if (rst && (state_q == S_FETCH))
         imem.req = outstanding_q | (count_q < FULL_CNT);
   end

   // Fetch PC and the redirect target parked while draining in DROP
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q    <= RESET_PC;
         drop_target_q <= RESET_PC;
      end else if (redirect) begin
         if (redirect_drop) drop_target_q <= target;
         else               fetch_pc_q    <= target;
      end else if ((state_q == S_DROP) && ack_valid) begin
         fetch_pc_q <= drop_target_q;
      end else if (push) begin
         fetch_pc_q <= fetch_pc_q + 32'd4;
      end
   end

   // Tracks the single request the memory has accepted but not yet answered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           outstanding_q <= 1'b0;
      else if (ack_valid) outstanding_q <= 1'b0;
      else if (imem.req)  outstanding_q <= 1'b1;
   end

   // Queue pointers and occupancy; a redirect empties the queue
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || redirect) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) tail_q <= ptr_inc(tail_q);
         if (pop)  head_q <= ptr_inc(head_q);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Queue storage: {pc, inst} written at the tail on each accepted response
   // NOTE: storage has no reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[tail_q]   <= fetch_pc_q;
         q_inst[tail_q] <= imem.rdata;
      end
   end

   // IF/ID register: bubble on redirect, hold on stall, else pop or bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc         <= 32'h0000_0000;
         inst       <= NOP_INST;
         inst_valid <= 1'b0;
      end else if (redirect) begin
         pc         <= 32'h0000_0000;
         inst       <= NOP_INST;
         inst_valid <= 1'b0;
      end else if (!stall) begin
         if (count_q != '0) begin
            pc         <= q_pc[head_q];
            inst       <= q_inst[head_q];
            inst_valid <= 1'b1;
         end else begin
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
         end
      end
   end

   // Request gating must make a push into a full queue impossible
   a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
      push |-> (count_q != FULL_CNT));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: zero-wait and 3-cycle-latency instruction
// memory models, stall hold, redirects (clean and racing a request), PC wrap,
// and reset with a request in flight.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        inst_valid;

   int errors = 0;
   int checks = 0;

   if_stage_if imem ();

   if_stage dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem         (imem),
      .pc           (pc),
      .inst         (inst),
      .inst_valid   (inst_valid)
   );

   always #5 clk = ~clk;

   // Instruction memory: zero-wait (ack = req) or 3-cycle latency (ack two
   // cycles after the request is first seen). Data word = address ^ KEY.
   // The latency model ignores reset so a late ack can land inside reset.
   logic        mem_zero;
   logic        lat_busy = 1'b0;
   logic [1:0]  lat_cnt  = 2'd0;
   logic [31:0] lat_addr = 32'h0;

   assign imem.ack   = mem_zero ? imem.req : (lat_busy && (lat_cnt == 2'd0));
   assign imem.rdata = (mem_zero ? imem.addr : lat_addr) ^ KEY;

   always @(posedge clk) begin
      if (mem_zero) begin
         lat_busy <= 1'b0;
      end else if (lat_busy) begin
         if (lat_cnt == 2'd0) lat_busy <= 1'b0;
         else                 lat_cnt  <= lat_cnt - 2'd1;
      end else if (imem.req) begin
         lat_busy <= 1'b1;
         lat_cnt  <= 2'd1;
         lat_addr <= imem.addr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; mem_zero = 1'b1; stall = 1'b0;
      branch_taken = 1'b0; branch_addr = 32'h0;
      repeat (3) tick();
      checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem.req); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc); end
      checks++; if (inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", inst, NOP); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] exp_pc;
      rst = 1'b1;
      #1;
      checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin
         errors++; $display("FAIL zw_first_req: got req=%b addr=%h want 1/0", imem.req, imem.addr); end
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++; if (imem.addr !== 32'(4 * k)) begin
            errors++; $display("FAIL zw_addr[%0d]: got %h want %h", k, imem.addr, 32'(4 * k)); end
         if (k == 1) begin
            checks++; if (inst_valid !== 1'b0) begin
               errors++; $display("FAIL zw_first_bubble: got valid=%b want 0", inst_valid); end
         end else begin
            exp_pc = 32'(4 * (k - 2));
            checks++; if (inst_valid !== 1'b1 || pc !== exp_pc || inst !== (exp_pc ^ KEY)) begin
               errors++; $display("FAIL zw_out[%0d]: got v=%b pc=%h inst=%h want 1/%h/%h",
                                  k, inst_valid, pc, inst, exp_pc, exp_pc ^ KEY); end
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] exp_pc;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (inst_valid !== 1'b1 || pc !== 32'h10 || inst !== (32'h10 ^ KEY)) begin
            errors++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h inst=%h want 1/10/%h",
                               i, inst_valid, pc, inst, 32'h10 ^ KEY); end
         checks++; if (imem.req !== 1'b0) begin
            errors++; $display("FAIL stall_req_full[%0d]: got %b want 0", i, imem.req); end
      end
      stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_pc = 32'h14 + 32'(4 * i);
         checks++; if (inst_valid !== 1'b1 || pc !== exp_pc || inst !== (exp_pc ^ KEY)) begin
            errors++; $display("FAIL stall_resume[%0d]: got v=%b pc=%h inst=%h want 1/%h/%h",
                               i, inst_valid, pc, inst, exp_pc, exp_pc ^ KEY); end
      end
   endtask

   task automatic test_redirect();
      branch_taken = 1'b1; branch_addr = 32'h0000_0102;
      tick();
      branch_taken = 1'b0;
      checks++; if (inst_valid !== 1'b0 || pc !== 32'h0 || inst !== NOP) begin
         errors++; $display("FAIL br_bubble: got v=%b pc=%h inst=%h want 0/0/%h", inst_valid, pc, inst, NOP); end
      checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h100) begin
         errors++; $display("FAIL br_req: got req=%b addr=%h want 1/100", imem.req, imem.addr); end
      tick();
      checks++; if (inst_valid !== 1'b0) begin
         errors++; $display("FAIL br_second_bubble: got valid=%b want 0", inst_valid); end
      tick();
      checks++; if (inst_valid !== 1'b1 || pc !== 32'h100 || inst !== (32'h100 ^ KEY)) begin
         errors++; $display("FAIL br_target: got v=%b pc=%h inst=%h want 1/100/%h",
                            inst_valid, pc, inst, 32'h100 ^ KEY); end
   endtask

   task automatic test_wrap();
      logic [31:0] top;
      top = 32'hFFFF_FFFC;
      branch_taken = 1'b1; branch_addr = top;
      tick();
      branch_taken = 1'b0;
      checks++; if (imem.addr !== top) begin
         errors++; $display("FAIL wrap_top_addr: got %h want %h", imem.addr, top); end
      tick();
      checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin
         errors++; $display("FAIL wrap_zero_addr: got req=%b addr=%h want 1/0", imem.req, imem.addr); end
      tick();
      checks++; if (inst_valid !== 1'b1 || pc !== top || inst !== (top ^ KEY)) begin
         errors++; $display("FAIL wrap_top_out: got v=%b pc=%h inst=%h want 1/%h/%h",
                            inst_valid, pc, inst, top, top ^ KEY); end
      tick();
      checks++; if (inst_valid !== 1'b1 || pc !== 32'h0 || inst !== KEY) begin
         errors++; $display("FAIL wrap_zero_out: got v=%b pc=%h inst=%h want 1/0/%h",
                            inst_valid, pc, inst, KEY); end
   endtask

   task automatic test_drop();
      bit seen;
      rst = 1'b0; mem_zero = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      #1;
      checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin
         errors++; $display("FAIL lat_first_req: got req=%b addr=%h want 1/0", imem.req, imem.addr); end
      repeat (4) tick();
      checks++; if (inst_valid !== 1'b1 || pc !== 32'h0 || inst !== KEY) begin
         errors++; $display("FAIL lat_first_out: got v=%b pc=%h inst=%h want 1/0/%h", inst_valid, pc, inst, KEY); end
      repeat (3) tick();
      checks++; if (inst_valid !== 1'b1 || pc !== 32'h4 || imem.req !== 1'b1 || imem.addr !== 32'h8) begin
         errors++; $display("FAIL lat_second: got v=%b pc=%h req=%b addr=%h want 1/4/1/8",
                            inst_valid, pc, imem.req, imem.addr); end
      // The request to 0x8 is outstanding and unacked here
      branch_taken = 1'b1; branch_addr = 32'h0000_0200;
      tick();
      branch_taken = 1'b0;
      checks++; if (inst_valid !== 1'b0 || imem.req !== 1'b0) begin
         errors++; $display("FAIL drop_wait: got v=%b req=%b want 0/0", inst_valid, imem.req); end
      tick();
      checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h200) begin
         errors++; $display("FAIL drop_next_req: got req=%b addr=%h want 1/200", imem.req, imem.addr); end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (inst_valid) begin seen = 1'b1; break; end
      end
      checks++; if (!seen || pc !== 32'h200 || inst !== (32'h200 ^ KEY)) begin
         errors++; $display("FAIL drop_first_valid: got seen=%b pc=%h inst=%h want 1/200/%h",
                            seen, pc, inst, 32'h200 ^ KEY); end
   endtask

   task automatic test_reset_outstanding();
      bit seen;
      checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h204) begin
         errors++; $display("FAIL rst_pre_req: got req=%b addr=%h want 1/204", imem.req, imem.addr); end
      rst = 1'b0;
      #1;
      checks++; if (imem.req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h0 || inst !== NOP) begin
         errors++; $display("FAIL rst_async: got req=%b v=%b pc=%h inst=%h want 0/0/0/%h",
                            imem.req, inst_valid, pc, inst, NOP); end
      repeat (3) tick();
      rst = 1'b1;
      #1;
      checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin
         errors++; $display("FAIL rst_first_req: got req=%b addr=%h want 1/0", imem.req, imem.addr); end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (inst_valid) begin seen = 1'b1; break; end
      end
      checks++; if (!seen || pc !== 32'h0 || inst !== KEY) begin
         errors++; $display("FAIL rst_first_valid: got seen=%b pc=%h inst=%h want 1/0/%h", seen, pc, inst, KEY); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_stall();
      test_redirect();
      test_wrap();
      test_drop();
      test_reset_outstanding();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
